// File: rtl/xadc_drp_sequencer.sv
// Round-robin DRP read sequencer for up to four XADC aux slots, one read per eoc.
// Optional per-slot 4-sample averaging is built when XADC_SEQ_AVG_EN is defined.
module xadc_drp_sequencer #(
    parameter logic [6:0] CH0_ADDR = 7'h1E,
    parameter logic [6:0] CH1_ADDR = 7'h17,
    parameter logic [6:0] CH2_ADDR = 7'h1F,
    parameter logic [6:0] CH3_ADDR = 7'h16,
    parameter int         TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ch_en,
    input  logic        eoc,
    output logic        den,
    output logic [6:0]  daddr,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic [31:0] samples,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    input  logic        clr_err,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [1:0] nxt_sel;
    logic [9:0] timer;
    logic       unused_low;

    assign unused_low = ^do_in[7:0];

    function automatic logic [6:0] slot_addr(input logic [1:0] s);
        case (s)
            2'd0:    slot_addr = CH0_ADDR;
            2'd1:    slot_addr = CH1_ADDR;
            2'd2:    slot_addr = CH2_ADDR;
            default: slot_addr = CH3_ADDR;
        endcase
    endfunction

    // Scan downward so the smallest offset from ptr wins; 2-bit sum wraps 3->0.
    always_comb begin
        nxt_sel = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (ch_en[ptr + 2'(i)])
                nxt_sel = ptr + 2'(i);
        end
    end

`ifdef XADC_SEQ_AVG_EN
    logic [9:0] acc [4];
    logic [1:0] cnt [4];
    logic [9:0] acc_sum;

    assign acc_sum = acc[sel] + {2'b00, do_in[15:8]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            sel          <= 2'd0;
            timer        <= 10'd0;
            den          <= 1'b0;
            daddr        <= CH0_ADDR;
            samples      <= 32'd0;
            sample_valid <= 1'b0;
            sample_ch    <= 2'd0;
            err_timeout  <= 1'b0;
`ifdef XADC_SEQ_AVG_EN
            for (int i = 0; i < 4; i++) begin
                acc[i] <= 10'd0;
                cnt[i] <= 2'd0;
            end
`endif
        end else begin
            den          <= 1'b0;
            sample_valid <= 1'b0;
            // A timeout set below overrides this clear in the same cycle.
            if (clr_err)
                err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (eoc && (ch_en != 4'd0)) begin
                        sel   <= nxt_sel;
                        daddr <= slot_addr(nxt_sel);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    den   <= 1'b1;
                    timer <= 10'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (drdy) begin
`ifdef XADC_SEQ_AVG_EN
                        if (cnt[sel] == 2'd3) begin
                            samples[8*sel +: 8] <= acc_sum[9:2];
                            sample_valid        <= 1'b1;
                            sample_ch           <= sel;
                            acc[sel]            <= 10'd0;
                            cnt[sel]            <= 2'd0;
                        end else begin
                            acc[sel] <= acc_sum;
                            cnt[sel] <= cnt[sel] + 2'd1;
                        end
`else
                        samples[8*sel +: 8] <= do_in[15:8];
                        sample_valid        <= 1'b1;
                        sample_ch           <= sel;
`endif
                        ptr   <= sel + 2'd1;
                        state <= IDLE;
                    end else if (timer == 10'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
`ifdef XADC_SEQ_AVG_EN
                        acc[sel] <= 10'd0;
                        cnt[sel] <= 2'd0;
`endif
                        ptr   <= sel + 2'd1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 10'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer: vector table plus random reads against a slot-level model.
// Model follows XADC_SEQ_AVG_EN the same way the design does.
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en;
    logic        eoc;
    logic        den;
    logic [6:0]  daddr;
    logic        drdy;
    logic [15:0] do_in;
    logic [31:0] samples;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic        clr_err;
    logic        err_timeout;

    xadc_drp_sequencer dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .eoc(eoc), .den(den), .daddr(daddr),
        .drdy(drdy), .do_in(do_in), .samples(samples), .sample_valid(sample_valid),
        .sample_ch(sample_ch), .clr_err(clr_err), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---- slot-level reference model ----
    int   m_ptr;
    logic [7:0] m_s [4];
    int   m_acc [4];
    int   m_cnt [4];

    function automatic logic [6:0] addr_of(input int s);
        case (s)
            0: return 7'h1E;
            1: return 7'h17;
            2: return 7'h1F;
            default: return 7'h16;
        endcase
    endfunction

    function automatic void m_reset();
        m_ptr = 0;
        for (int i = 0; i < 4; i++) begin m_s[i] = 8'h00; m_acc[i] = 0; m_cnt[i] = 0; end
    endfunction

    function automatic int m_sel(input logic [3:0] en);
        for (int i = 0; i < 4; i++)
            if (en[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        return -1;
    endfunction

    function automatic bit m_success(input int s, input logic [7:0] b);
        bit v;
        m_ptr = (s + 1) % 4;
`ifdef XADC_SEQ_AVG_EN
        m_acc[s] += int'(b);
        m_cnt[s] += 1;
        v = (m_cnt[s] == 4);
        if (v) begin m_s[s] = 8'(m_acc[s] / 4); m_acc[s] = 0; m_cnt[s] = 0; end
`else
        m_s[s] = b;
        v = 1'b1;
`endif
        return v;
    endfunction

    function automatic void m_timeout(input int s);
        m_ptr = (s + 1) % 4;
        m_acc[s] = 0;
        m_cnt[s] = 0;
    endfunction

    function automatic logic [31:0] m_samples();
        return {m_s[3], m_s[2], m_s[1], m_s[0]};
    endfunction

    // ---- stimulus helpers (all driving/sampling on negedge) ----
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; eoc = 1'b0; drdy = 1'b0; clr_err = 1'b0; do_in = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // Pulse eoc and wait for den; returns the slot the model expects.
    task automatic issue(input logic [3:0] en, input logic [6:0] ea, output int slot);
        int lat;
        ch_en = en;
        slot  = m_sel(en);
        eoc   = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) eoc = 1'b0;
        end while (!den && lat < 8);
        chk("den latency", lat, 2);
        chk("daddr", {25'd0, daddr}, {25'd0, ea});
    endtask

    task automatic do_read(input logic [3:0] en, input logic [15:0] d, input int dly,
                           input logic [6:0] ea, input logic [1:0] ec);
        int slot;
        bit ev;
        issue(en, ea, slot);
        repeat (dly) @(negedge clk);
        drdy = 1'b1; do_in = d;
        @(negedge clk);
        drdy = 1'b0;
        ev = m_success(slot, d[15:8]);
        chk("sample_valid", {31'd0, sample_valid}, {31'd0, ev});
        if (ev) chk("sample_ch", {30'd0, sample_ch}, {30'd0, ec});
        chk("samples", samples, m_samples());
        chk("err after read", {31'd0, err_timeout}, 32'd0);
        @(negedge clk);
        chk("valid one-shot", {31'd0, sample_valid}, 32'd0);
    endtask

    task automatic do_timeout(input logic [3:0] en, input bit hold_clr);
        int slot, n;
        bit seen_v;
        issue(en, addr_of(m_sel(en)), slot);
        clr_err = hold_clr;
        n = 0; seen_v = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (sample_valid) seen_v = 1'b1;
        end while (!err_timeout && n < 400);
        m_timeout(slot);
        chk("timeout cycles", n, 256);
        chk("no valid on timeout", {31'd0, seen_v}, 32'd0);
        chk("samples kept on timeout", samples, m_samples());
        @(negedge clk);
        if (hold_clr) begin
            chk("clr after set", {31'd0, err_timeout}, 32'd0);
            clr_err = 1'b0;
        end else begin
            chk("err sticky", {31'd0, err_timeout}, 32'd1);
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
            chk("err cleared", {31'd0, err_timeout}, 32'd0);
        end
    endtask

    typedef struct {
        bit         rst_b;
        logic [3:0] en;
        logic [15:0] d;
        int         dly;
        logic [6:0] ea;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int dens, slot;
        bit ev;
        logic [3:0] en;

        tbl[0] = '{1, 4'hF, 16'hA512, 3, 7'h1E, 2'd0};
        tbl[1] = '{0, 4'hF, 16'hA534, 3, 7'h17, 2'd1};
        tbl[2] = '{0, 4'hF, 16'hA556, 3, 7'h1F, 2'd2};
        tbl[3] = '{0, 4'hF, 16'hA578, 3, 7'h16, 2'd3};
        tbl[4] = '{0, 4'hF, 16'hA59A, 3, 7'h1E, 2'd0};
        tbl[5] = '{1, 4'h5, 16'h5A01, 3, 7'h1E, 2'd0};
        tbl[6] = '{0, 4'h5, 16'h3C02, 1, 7'h1F, 2'd2};
        tbl[7] = '{0, 4'h5, 16'h7E03, 0, 7'h1E, 2'd0};
        tbl[8] = '{0, 4'h5, 16'hC304, 5, 7'h1F, 2'd2};

        rst = 1'b1; ch_en = 4'h0; eoc = 1'b0; drdy = 1'b0; do_in = 16'h0; clr_err = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset den", {31'd0, den}, 32'd0);
        chk("reset daddr", {25'd0, daddr}, 32'h1E);
        chk("reset samples", samples, 32'd0);
        chk("reset valid", {31'd0, sample_valid}, 32'd0);
        chk("reset ch", {30'd0, sample_ch}, 32'd0);
        chk("reset err", {31'd0, err_timeout}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rst_b) do_reset();
            do_read(tbl[i].en, tbl[i].d, tbl[i].dly, tbl[i].ea, tbl[i].ec);
        end
        chk("disabled slots untouched", {16'd0, samples[31:24], samples[15:8]}, 32'd0);

        // No enabled slots: eoc must never start a read.
        ch_en = 4'h0; dens = 0;
        for (int i = 0; i < 100; i++) begin
            eoc = 1'b1; @(negedge clk); if (den) dens++;
            eoc = 1'b0; @(negedge clk); if (den) dens++;
        end
        chk("no den with ch_en=0", dens, 0);

        // Timeout, then the next slot; drdy exactly at the last timer value; set beats clear.
        do_reset();
        do_timeout(4'hF, 1'b0);
        do_read(4'hF, 16'h6611, 3, addr_of(m_sel(4'hF)), 2'(m_sel(4'hF)));
        do_read(4'hF, 16'h7722, 255, addr_of(m_sel(4'hF)), 2'(m_sel(4'hF)));
        do_timeout(4'hF, 1'b1);

        // eoc held high through WAIT: exactly one den.
        ch_en = 4'hF; slot = m_sel(4'hF); dens = 0;
        eoc = 1'b1;
        repeat (5) begin @(negedge clk); if (den) dens++; end
        chk("held-eoc daddr", {25'd0, daddr}, {25'd0, addr_of(slot)});
        drdy = 1'b1; do_in = 16'hB0B0; eoc = 1'b0;
        @(negedge clk);
        drdy = 1'b0;
        ev = m_success(slot, 8'hB0);
        chk("held-eoc valid", {31'd0, sample_valid}, {31'd0, ev});
        repeat (6) begin @(negedge clk); if (den) dens++; end
        chk("held-eoc den count", dens, 1);
        chk("held-eoc samples", samples, m_samples());

        // Random reads against the model.
        for (int i = 0; i < 40; i++) begin
            en = 4'($urandom_range(0, 15));
            if (m_sel(en) < 0) begin
                ch_en = en; dens = 0;
                eoc = 1'b1; @(negedge clk); eoc = 1'b0;
                repeat (6) begin @(negedge clk); if (den) dens++; end
                chk("rand no den", dens, 0);
            end else begin
                do_read(en, 16'($urandom), int'($urandom_range(0, 12)),
                        addr_of(m_sel(en)), 2'(m_sel(en)));
            end
        end

        // Averaging sequence (plain capture when the feature is off).
        do_reset();
        do_read(4'h1, {8'd10, 8'h00}, 2, 7'h1E, 2'd0);
        do_read(4'h1, {8'd20, 8'h00}, 2, 7'h1E, 2'd0);
        do_read(4'h1, {8'd30, 8'h00}, 2, 7'h1E, 2'd0);
        do_read(4'h1, {8'd40, 8'h00}, 2, 7'h1E, 2'd0);
`ifdef XADC_SEQ_AVG_EN
        chk("avg result", {24'd0, samples[7:0]}, 32'd25);
`else
        chk("last capture", {24'd0, samples[7:0]}, 32'd40);
`endif
        do_read(4'h1, {8'd100, 8'h00}, 1, 7'h1E, 2'd0);
        do_read(4'h1, {8'd200, 8'h00}, 1, 7'h1E, 2'd0);
        do_timeout(4'h1, 1'b0);
        for (int i = 0; i < 4; i++)
            do_read(4'h1, {8'(8 * (i + 1)), 8'h55}, 1, 7'h1E, 2'd0);

        // Reset in WAIT; drdy after release must be ignored.
        ch_en = 4'hF;
        issue(4'hF, addr_of(m_sel(4'hF)), slot);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst den", {31'd0, den}, 32'd0);
        chk("mid rst daddr", {25'd0, daddr}, 32'h1E);
        chk("mid rst samples", samples, 32'd0);
        chk("mid rst ch", {30'd0, sample_ch}, 32'd0);
        rst = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        drdy = 1'b1; do_in = 16'hEEEE;
        @(negedge clk);
        drdy = 1'b0;
        chk("late drdy no valid", {31'd0, sample_valid}, 32'd0);
        @(negedge clk);
        chk("late drdy samples", samples, 32'd0);
        chk("late drdy no den", {31'd0, den}, 32'd0);
        do_read(4'hF, 16'h4242, 3, 7'h1E, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
